dp_sequencer: RTL and testbench

Micro-instruction issue controller sitting directly upstream of `datapath`. It buffers 10-bit micro-instructions in a small FIFO and issues at most one per clock as `ALUControl`/`addr1`/`addr2`/`addr3`/`wr`. It samples the datapath's `Zero`/`Overflow` flags back into status registers. This replaces hand-driven testbench stimulus with a sequenced instruction stream.

---
 rtl/dp_seq_pkg.sv | 41 ++++
 rtl/dp_seq_if.sv | 26 ++
 rtl/dp_seq_fifo.sv | 44 ++++
 rtl/dp_sequencer.sv | 111 +++++++++++
 tb/tb_dp_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_seq_pkg.sv
// rtl/dp_seq_pkg.sv - shared types and constants for the micro-instruction sequencer
package dp_seq_pkg;

  localparam int INST_W    = 10;
  localparam int WR_BIT    = 9;
  localparam int OP_MSB    = 8;
  localparam int OP_LSB    = 6;
  localparam int A1_MSB    = 5;
  localparam int A1_LSB    = 4;
  localparam int A2_MSB    = 3;
  localparam int A2_LSB    = 2;
  localparam int A3_MSB    = 1;
  localparam int A3_LSB    = 0;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [2:0] op;
    logic [1:0] a1;
    logic [1:0] a2;
    logic [1:0] a3;
  } inst_t;

  function automatic inst_t decode(logic [INST_W-1:0] raw);
    inst_t d;
    d.wr = raw[WR_BIT];
    d.op = raw[OP_MSB:OP_LSB];
    d.a1 = raw[A1_MSB:A1_LSB];
    d.a2 = raw[A2_MSB:A2_LSB];
    d.a3 = raw[A3_MSB:A3_LSB];
    return d;
  endfunction

endpackage

// File: rtl/dp_seq_if.sv
// rtl/dp_seq_if.sv - instruction stream and datapath control/flag bundle
interface dp_seq_if;
  import dp_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic [2:0]        ALUControl;
  logic [1:0]        addr1;
  logic [1:0]        addr2;
  logic [1:0]        addr3;
  logic              wr;
  logic              Zero;
  logic              Overflow;

  modport master (
    input  in_valid, in_inst, Zero, Overflow,
    output in_ready, ALUControl, addr1, addr2, addr3, wr
  );

  modport slave (
    output in_valid, in_inst, Zero, Overflow,
    input  in_ready, ALUControl, addr1, addr2, addr3, wr
  );

endinterface

// File: rtl/dp_seq_fifo.sv
// rtl/dp_seq_fifo.sv - synchronous FIFO with asynchronously reset pointers
module dp_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + (AW+1)'(1);
      if (pop && !empty)
        rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dp_sequencer.sv
// rtl/dp_sequencer.sv - micro-instruction issue controller for datapath
// DP_SEQ_OVF_TRAP_EN: halt on an overflowing write instead of only flagging it.
module dp_sequencer
  import dp_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  dp_seq_if.master         bus,
  input  logic             clear,
  output logic             busy,
  output logic             halted,
  output logic             zero_flag,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] issued_cnt
);

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [INST_W-1:0] head;
  logic              trap;
  logic              iss_vld;
  inst_t             iss;
  state_t            state;
  state_t            state_nxt;

  assign bus.in_ready = ~full;
  assign push         = bus.in_valid & ~full;

`ifdef DP_SEQ_OVF_TRAP_EN
  assign trap   = iss_vld & iss.wr & bus.Overflow & (state == ST_RUN);
  assign halted = (state == ST_HALT);
`else
  assign trap   = 1'b0;
  assign halted = 1'b0;
`endif

  // A trapping instruction is dropped, so the head stays queued for after clear.
  assign pop = (state == ST_RUN) & ~empty & ~trap;

  dp_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.in_inst),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_vld <= 1'b0;
      iss     <= '0;
    end else begin
      iss_vld <= pop;
      if (pop)
        iss <= decode(head);
    end
  end

  assign bus.ALUControl = iss.op;
  assign bus.addr1      = iss.a1;
  assign bus.addr2      = iss.a2;
  assign bus.addr3      = iss.a3;
  assign bus.wr         = iss_vld & iss.wr & ~trap;
  assign busy           = ~empty | iss_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_flag  <= 1'b0;
      ovf_sticky <= 1'b0;
      issued_cnt <= '0;
    end else begin
      if (iss_vld) begin
        zero_flag  <= bus.Zero;
        issued_cnt <= issued_cnt + CNT_W'(1);
      end
      // A new overflow outranks a clear arriving on the same edge.
      if (iss_vld && bus.Overflow)
        ovf_sticky <= 1'b1;
      else if (clear)
        ovf_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (trap)  state_nxt = ST_HALT;
      ST_HALT: if (clear) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// tb/tb_dp_sequencer.sv - directed self-checking bench for dp_sequencer
module tb_dp_sequencer;
  import dp_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        busy;
  logic        halted;
  logic        zero_flag;
  logic        ovf_sticky;
  logic [15:0] issued_cnt;

  int passed = 0;
  int total  = 0;

  logic [9:0] vals [6];

  dp_seq_if bus();

  dp_sequencer #(
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clear      (clear),
    .busy       (busy),
    .halted     (halted),
    .zero_flag  (zero_flag),
    .ovf_sticky (ovf_sticky),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0;
    bus.in_inst  = '0;
    bus.Zero     = 1'b0;
    bus.Overflow = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    total++; if (bus.wr !== 1'b0) $display("FAIL rst_wr got %0b want 0", bus.wr); else passed++;
    total++; if (bus.ALUControl !== 3'd0) $display("FAIL rst_alu got %0d want 0", bus.ALUControl); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_ready got %0b want 1", bus.in_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL rst_halted got %0b want 0", halted); else passed++;
    total++; if ({zero_flag, ovf_sticky} !== 2'b00) $display("FAIL rst_flags got %b want 00", {zero_flag, ovf_sticky}); else passed++;
    total++; if (issued_cnt !== 16'd0) $display("FAIL rst_cnt got %0d want 0", issued_cnt); else passed++;
    rst = 1'b0;
    tick();
    // Stream three instructions, then reset while one is being issued.
    bus.in_valid = 1'b1;
    bus.in_inst  = 10'h255; tick();
    bus.in_inst  = 10'h25C; tick();
    bus.in_inst  = 10'h255; tick();
    bus.in_valid = 1'b0;
    total++; if (bus.wr !== 1'b1) $display("FAIL mid_wr_pre got %0b want 1", bus.wr); else passed++;
    rst = 1'b1;
    #1;
    total++; if (bus.wr !== 1'b0) $display("FAIL mid_rst_wr got %0b want 0", bus.wr); else passed++;
    total++; if ({bus.ALUControl, bus.addr1, bus.addr2, bus.addr3} !== 9'd0) $display("FAIL mid_rst_fields got %h want 0", {bus.ALUControl, bus.addr1, bus.addr2, bus.addr3}); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL mid_rst_ready got %0b want 1", bus.in_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %0b want 0", busy); else passed++;
    total++; if (issued_cnt !== 16'd0) $display("FAIL mid_rst_cnt got %0d want 0", issued_cnt); else passed++;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    total++; if (busy !== 1'b0) $display("FAIL post_rst_busy got %0b want 0", busy); else passed++;
    total++; if (bus.wr !== 1'b0) $display("FAIL post_rst_wr got %0b want 0", bus.wr); else passed++;
    total++; if (issued_cnt !== 16'd0) $display("FAIL post_rst_cnt got %0d want 0", issued_cnt); else passed++;
  endtask

  task automatic test_single;
    bus.in_valid = 1'b1;
    bus.in_inst  = 10'h255;
    tick();
    bus.in_valid = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL single_busy_q got %0b want 1", busy); else passed++;
    total++; if (bus.wr !== 1'b0) $display("FAIL single_wr_early got %0b want 0", bus.wr); else passed++;
    tick();
    total++; if (bus.ALUControl !== 3'b001) $display("FAIL single_alu got %0d want 1", bus.ALUControl); else passed++;
    total++; if ({bus.addr1, bus.addr2, bus.addr3} !== 6'b010101) $display("FAIL single_addr got %b want 010101", {bus.addr1, bus.addr2, bus.addr3}); else passed++;
    total++; if (bus.wr !== 1'b1) $display("FAIL single_wr got %0b want 1", bus.wr); else passed++;
    total++; if (issued_cnt !== 16'd0) $display("FAIL single_cnt_pre got %0d want 0", issued_cnt); else passed++;
    tick();
    total++; if (issued_cnt !== 16'd1) $display("FAIL single_cnt got %0d want 1", issued_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_busy_end got %0b want 0", busy); else passed++;
    total++; if (bus.wr !== 1'b0) $display("FAIL single_wr_end got %0b want 0", bus.wr); else passed++;
    total++; if (bus.ALUControl !== 3'b001) $display("FAIL single_hold got %0d want 1", bus.ALUControl); else passed++;
  endtask

  task automatic test_flags;
    bus.in_valid = 1'b1;
    bus.in_inst  = 10'h25C; tick();
    bus.in_inst  = 10'h255; tick();
    bus.in_valid = 1'b0;
    bus.Zero = 1'b0;
    bus.Overflow = 1'b0;
    #1;
    total++; if ({bus.addr2, bus.addr3} !== 4'b1100) $display("FAIL flags_addr_a got %b want 1100", {bus.addr2, bus.addr3}); else passed++;
    total++; if (bus.wr !== 1'b1) $display("FAIL flags_wr_a got %0b want 1", bus.wr); else passed++;
    tick();
    bus.Zero = 1'b1;
    total++; if (zero_flag !== 1'b0) $display("FAIL flags_zero_a got %0b want 0", zero_flag); else passed++;
    total++; if (bus.addr3 !== 2'd1) $display("FAIL flags_addr_b got %0d want 1", bus.addr3); else passed++;
    tick();
    bus.Zero = 1'b0;
    total++; if (zero_flag !== 1'b1) $display("FAIL flags_zero_b got %0b want 1", zero_flag); else passed++;
    total++; if (ovf_sticky !== 1'b0) $display("FAIL flags_ovf got %0b want 0", ovf_sticky); else passed++;
    total++; if (issued_cnt !== 16'd3) $display("FAIL flags_cnt got %0d want 3", issued_cnt); else passed++;
  endtask

  task automatic test_clear_run;
    bus.in_valid = 1'b1;
    bus.in_inst  = 10'h05C;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.Overflow = 1'b1;
    clear = 1'b1;
    #1;
    total++; if (bus.wr !== 1'b0) $display("FAIL clr_wr got %0b want 0", bus.wr); else passed++;
    tick();
    bus.Overflow = 1'b0;
    clear = 1'b0;
    total++; if (ovf_sticky !== 1'b1) $display("FAIL clr_set_wins got %0b want 1", ovf_sticky); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL clr_halted got %0b want 0", halted); else passed++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (ovf_sticky !== 1'b0) $display("FAIL clr_ovf got %0b want 0", ovf_sticky); else passed++;
    total++; if (issued_cnt !== 16'd4) $display("FAIL clr_cnt got %0d want 4", issued_cnt); else passed++;
  endtask

  task automatic test_trap;
    bus.in_valid = 1'b1;
    bus.in_inst  = 10'h25C; tick();
    bus.in_inst  = 10'h255; tick();
    bus.in_valid = 1'b0;
    bus.Overflow = 1'b1;
    #1;
    total++; if (bus.addr2 !== 2'd3) $display("FAIL trap_issue got %0d want 3", bus.addr2); else passed++;
`ifdef DP_SEQ_OVF_TRAP_EN
    total++; if (bus.wr !== 1'b0) $display("FAIL trap_wr got %0b want 0", bus.wr); else passed++;
    tick();
    bus.Overflow = 1'b0;
    total++; if (halted !== 1'b1) $display("FAIL trap_halted got %0b want 1", halted); else passed++;
    total++; if (bus.wr !== 1'b0) $display("FAIL trap_wr_halt got %0b want 0", bus.wr); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL trap_busy got %0b want 1", busy); else passed++;
    total++; if (ovf_sticky !== 1'b1) $display("FAIL trap_ovf got %0b want 1", ovf_sticky); else passed++;
    total++; if (issued_cnt !== 16'd5) $display("FAIL trap_cnt got %0d want 5", issued_cnt); else passed++;
    repeat (3) tick();
    total++; if (halted !== 1'b1) $display("FAIL trap_hold_halt got %0b want 1", halted); else passed++;
    total++; if (bus.addr3 !== 2'd0) $display("FAIL trap_held got %0d want 0", bus.addr3); else passed++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (halted !== 1'b0) $display("FAIL trap_resume got %0b want 0", halted); else passed++;
    total++; if (ovf_sticky !== 1'b0) $display("FAIL trap_ovf_clr got %0b want 0", ovf_sticky); else passed++;
    total++; if (bus.wr !== 1'b0) $display("FAIL trap_wr_clr got %0b want 0", bus.wr); else passed++;
    tick();
    total++; if ({bus.addr2, bus.addr3} !== 4'b0101) $display("FAIL trap_next got %b want 0101", {bus.addr2, bus.addr3}); else passed++;
    total++; if (bus.wr !== 1'b1) $display("FAIL trap_next_wr got %0b want 1", bus.wr); else passed++;
    tick();
`else
    total++; if (bus.wr !== 1'b1) $display("FAIL notrap_wr got %0b want 1", bus.wr); else passed++;
    tick();
    bus.Overflow = 1'b0;
    total++; if (ovf_sticky !== 1'b1) $display("FAIL notrap_ovf got %0b want 1", ovf_sticky); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL notrap_halted got %0b want 0", halted); else passed++;
    total++; if ({bus.addr2, bus.addr3} !== 4'b0101) $display("FAIL notrap_next got %b want 0101", {bus.addr2, bus.addr3}); else passed++;
    total++; if (bus.wr !== 1'b1) $display("FAIL notrap_next_wr got %0b want 1", bus.wr); else passed++;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (ovf_sticky !== 1'b0) $display("FAIL notrap_ovf_clr got %0b want 0", ovf_sticky); else passed++;
`endif
    total++; if (issued_cnt !== 16'd6) $display("FAIL trap_cnt_end got %0d want 6", issued_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL trap_busy_end got %0b want 0", busy); else passed++;
  endtask

  task automatic test_back_to_back;
    vals[0] = 10'h0E4; vals[1] = 10'h11B; vals[2] = 10'h1A7;
    vals[3] = 10'h06D; vals[4] = 10'h2F0; vals[5] = 10'h30F;
`ifdef DP_SEQ_OVF_TRAP_EN
    bus.in_valid = 1'b1;
    bus.in_inst  = 10'h200;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.Overflow = 1'b1;
    tick();
    bus.Overflow = 1'b0;
    total++; if (halted !== 1'b1) $display("FAIL b2b_halt got %0b want 1", halted); else passed++;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_inst  = vals[i];
      #1;
      total++; if (bus.in_ready !== (i < 4)) $display("FAIL b2b_ready_%0d got %0b want %0b", i, bus.in_ready, (i < 4)); else passed++;
      tick();
    end
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_full got %0b want 0", bus.in_ready); else passed++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (bus.wr !== 1'b0) $display("FAIL b2b_clr_wr got %0b want 0", bus.wr); else passed++;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if ({bus.ALUControl, bus.addr1, bus.addr2, bus.addr3} !== vals[k][8:0]) $display("FAIL b2b_fields_%0d got %h want %h", k, {bus.ALUControl, bus.addr1, bus.addr2, bus.addr3}, vals[k][8:0]); else passed++;
      total++; if (bus.wr !== vals[k][9]) $display("FAIL b2b_wr_%0d got %0b want %0b", k, bus.wr, vals[k][9]); else passed++;
    end
    tick();
    total++; if (issued_cnt !== 16'd11) $display("FAIL b2b_cnt got %0d want 11", issued_cnt); else passed++;
`else
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = (i < 6);
      bus.in_inst  = (i < 6) ? vals[i] : 10'h000;
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_%0d got %0b want 1", i, bus.in_ready); else passed++;
      if (i >= 2) begin
        total++; if ({bus.ALUControl, bus.addr1, bus.addr2, bus.addr3} !== vals[i-2][8:0]) $display("FAIL b2b_fields_%0d got %h want %h", i-2, {bus.ALUControl, bus.addr1, bus.addr2, bus.addr3}, vals[i-2][8:0]); else passed++;
        total++; if (bus.wr !== vals[i-2][9]) $display("FAIL b2b_wr_%0d got %0b want %0b", i-2, bus.wr, vals[i-2][9]); else passed++;
      end
      tick();
    end
    total++; if (issued_cnt !== 16'd12) $display("FAIL b2b_cnt got %0d want 12", issued_cnt); else passed++;
`endif
    total++; if (busy !== 1'b0) $display("FAIL b2b_busy got %0b want 0", busy); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_end got %0b want 1", bus.in_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_flags();
    test_clear_run();
    test_trap();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
